// File: rtl/fft512_pkg.sv
// rtl/fft512_pkg.sv - shared constants, FSM states and helpers for the PPG frame source
package fft512_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_FFT_LEN_LOG2 = 9;
    localparam int DEF_CFG_W        = 16;
    localparam int CFG_FWD_INV_BIT  = 0;

    typedef enum logic [2:0] {
        ST_CFG,
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_DONE
    } state_e;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - per-channel sample store, simple dual-port, registered read-first
module sample_ram
    import fft512_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FFT_LEN_LOG2 = DEF_FFT_LEN_LOG2,
    parameter int NUM_CH       = 1,
    parameter int CH_W         = ch_w(NUM_CH)
)(
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [FFT_LEN_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [CH_W-1:0]         rd_ch,
    input  logic [FFT_LEN_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int DEPTH  = NUM_CH << FFT_LEN_LOG2;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_ok;

    always_comb begin
        wr_idx = ADDR_W'({wr_ch, wr_addr});
        rd_idx = ADDR_W'({rd_ch, rd_addr});
        wr_ok  = wr_en && (32'(wr_ch) < NUM_CH);
    end

    // Read data only moves on rd_en so a stalled consumer sees stable data
    // even if the same location is rewritten meanwhile.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ppg_frame_source.sv
// rtl/ppg_frame_source.sv - streams zero-padded per-channel PPG frames and the FFT config word
module ppg_frame_source
    import fft512_pkg::*;
#(
    parameter int  DATA_W       = DEF_DATA_W,
    parameter int  FFT_LEN_LOG2 = DEF_FFT_LEN_LOG2,
    parameter int  NUM_CH       = 1,
    parameter int  CFG_W        = DEF_CFG_W,
    parameter int  FWD_INV      = 1,
    localparam int CH_W         = ch_w(NUM_CH)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [FFT_LEN_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    input  logic                    continuous,
    input  logic [FFT_LEN_LOG2:0]   num_samples,
    output logic [2*DATA_W-1:0]     m_axis_data_tdata,
    output logic                    m_axis_data_tvalid,
    input  logic                    m_axis_data_tready,
    output logic                    m_axis_data_tlast,
    output logic [CH_W-1:0]         m_axis_data_tuser,
    output logic [CFG_W-1:0]        m_axis_config_tdata,
    output logic                    m_axis_config_tvalid,
    input  logic                    m_axis_config_tready,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_count
);

    localparam logic [FFT_LEN_LOG2:0]   N_SMP    = {1'b1, {FFT_LEN_LOG2{1'b0}}};
    localparam logic [FFT_LEN_LOG2-1:0] K_LAST   = '1;
    localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CFG_W-1:0]        CFG_WORD = CFG_W'(FWD_INV != 0) << CFG_FWD_INV_BIT;

    state_e                  state_q, state_d;
    logic [FFT_LEN_LOG2:0]   ns_q, ns_d;
    logic [FFT_LEN_LOG2-1:0] rd_k_q, rd_k_d;
    logic [CH_W-1:0]         rd_ch_q, rd_ch_d;
    logic                    fetch_done_q, fetch_done_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [CH_W-1:0]         out_user_q, out_user_d;
    logic                    out_keep_q, out_keep_d;
    logic                    cfg_valid_q, cfg_valid_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic [15:0]             frame_count_q, frame_count_d;

    logic [FFT_LEN_LOG2:0]   ns_clamped;
    logic                    adv;
    logic                    fetch;
    logic                    begin_round;
    logic [DATA_W-1:0]       ram_rd_data;

    sample_ram #(
        .DATA_W       (DATA_W),
        .FFT_LEN_LOG2 (FFT_LEN_LOG2),
        .NUM_CH       (NUM_CH),
        .CH_W         (CH_W)
    ) u_sample_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (fetch),
        .rd_ch   (rd_ch_q),
        .rd_addr (rd_k_q),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        ns_clamped = (num_samples > N_SMP) ? N_SMP : num_samples;
        // The RAM output register plus the sideband flops form the single
        // output stage; it only advances when empty or being accepted.
        adv   = !out_valid_q || m_axis_data_tready;
        fetch = adv && ((state_q == ST_PRIME) ||
                        ((state_q == ST_STREAM) && !fetch_done_q));

        state_d       = state_q;
        ns_d          = ns_q;
        rd_k_d        = rd_k_q;
        rd_ch_d       = rd_ch_q;
        fetch_done_d  = fetch_done_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_user_d    = out_user_q;
        out_keep_d    = out_keep_q;
        cfg_valid_d   = cfg_valid_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        begin_round   = 1'b0;

        if (adv) begin
            out_valid_d = fetch;
            out_last_d  = fetch && (rd_k_q == K_LAST);
            out_user_d  = rd_ch_q;
            out_keep_d  = fetch && ({1'b0, rd_k_q} < ns_q);
        end

        if (fetch) begin
            rd_k_d = rd_k_q + 1'b1;
            if (rd_k_q == K_LAST) begin
                if (rd_ch_q == CH_LAST) begin
                    fetch_done_d = 1'b1;
                end else begin
                    rd_ch_d = rd_ch_q + 1'b1;
                end
            end
        end

        case (state_q)
            ST_CFG: begin
                cfg_valid_d = 1'b1;
                if (cfg_valid_q && m_axis_config_tready) begin
                    cfg_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    begin_round = 1'b1;
                end
            end
            ST_PRIME: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // Once everything is fetched, the only beat left is the final TLAST.
                if (fetch_done_q && out_valid_q && out_last_q && m_axis_data_tready) begin
                    state_d       = ST_DONE;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            ST_DONE: begin
                if (continuous) begin
                    begin_round = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_CFG;
            end
        endcase

        if (begin_round) begin
            state_d      = ST_PRIME;
            ns_d         = ns_clamped;
            rd_k_d       = '0;
            rd_ch_d      = '0;
            fetch_done_d = 1'b0;
            busy_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_CFG;
            ns_q          <= '0;
            rd_k_q        <= '0;
            rd_ch_q       <= '0;
            fetch_done_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_user_q    <= '0;
            out_keep_q    <= 1'b0;
            cfg_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ns_q          <= ns_d;
            rd_k_q        <= rd_k_d;
            rd_ch_q       <= rd_ch_d;
            fetch_done_q  <= fetch_done_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_user_q    <= out_user_d;
            out_keep_q    <= out_keep_d;
            cfg_valid_q   <= cfg_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Padding beats and idle cycles present zero regardless of stale RAM output.
    assign m_axis_data_tdata    = {{DATA_W{1'b0}}, (out_keep_q ? ram_rd_data : {DATA_W{1'b0}})};
    assign m_axis_data_tvalid   = out_valid_q;
    assign m_axis_data_tlast    = out_last_q;
    assign m_axis_data_tuser    = out_user_q;
    assign m_axis_config_tdata  = cfg_valid_q ? CFG_WORD : {CFG_W{1'b0}};
    assign m_axis_config_tvalid = cfg_valid_q;
    assign busy                 = busy_q;
    assign frame_done           = frame_done_q;
    assign frame_count          = frame_count_q;

endmodule
